// File: rtl/adventure_fsm_gen.sv
// adventure_fsm_gen: seven-room adventure game engine with lives, respawn,
// a saturating accepted-move counter, an illegal-input pulse and an optional
// move-limit timeout.
//
// Optional feature: define ADV_MOVE_LIMIT_EN to enable the move-limit timeout.
//
// Parameters:
//   LIVES      lives at reset (1 .. 2^CNT_W-1)
//   CNT_W      width of the lives and move counters
//   MOVE_LIMIT accepted-move budget when the timeout is compiled in
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   n, s, e, w direction buttons, sampled every rising edge
//   room       one-hot current room ([0] Cave .. [6] Graveyard)
//   win        high while in Victory Vault
//   d          high while in Grievous Graveyard
//   sword      sword held
//   lives      lives remaining
//   moves      accepted moves since reset, saturating
//   bump       one-cycle pulse after an edge that sampled an invalid input
module adventure_fsm_gen #(
  parameter int unsigned LIVES      = 1,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned MOVE_LIMIT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             n,
  input  logic             s,
  input  logic             e,
  input  logic             w,
  output logic [6:0]       room,
  output logic             win,
  output logic             d,
  output logic             sword,
  output logic [CNT_W-1:0] lives,
  output logic [CNT_W-1:0] moves,
  output logic             bump
);

  // One-hot encoding doubles as the room output.
  typedef enum logic [6:0] {
    StCave   = 7'b0000001,
    StTunnel = 7'b0000010,
    StRiver  = 7'b0000100,
    StStash  = 7'b0001000,
    StDen    = 7'b0010000,
    StVault  = 7'b0100000,
    StGrave  = 7'b1000000
  } room_e;

  localparam logic [CNT_W-1:0] LivesInit = CNT_W'(LIVES);

`ifdef ADV_MOVE_LIMIT_EN
  localparam logic [CNT_W-1:0] MoveMax = CNT_W'(MOVE_LIMIT);
  logic timeout;
  assign timeout = (moves == MoveMax);
`else
  localparam logic [CNT_W-1:0] MoveMax = {CNT_W{1'b1}};
  logic timeout;
  logic unused_move_limit;
  assign timeout           = 1'b0;
  assign unused_move_limit = ^MOVE_LIMIT;
`endif

  room_e state;
  room_e dest;
  logic  exit_ok;
  logic  single;
  logic  any_btn;
  logic  [3:0] btn;

  assign btn     = {n, s, e, w};
  assign any_btn = |btn;
  // Exactly one button: non-zero with no second bit set.
  assign single  = any_btn && ((btn & (btn - 4'd1)) == 4'd0);
  assign room    = state;

  // Exit decode; only meaningful when a single button is pressed.
  always_comb begin
    exit_ok = 1'b0;
    dest    = state;
    unique case (state)
      StCave: begin
        if (e) begin exit_ok = 1'b1; dest = StTunnel; end
      end
      StTunnel: begin
        if (w)      begin exit_ok = 1'b1; dest = StCave;  end
        else if (s) begin exit_ok = 1'b1; dest = StRiver; end
      end
      StRiver: begin
        if (n)      begin exit_ok = 1'b1; dest = StTunnel; end
        else if (w) begin exit_ok = 1'b1; dest = StStash;  end
        else if (e) begin exit_ok = 1'b1; dest = StDen;    end
      end
      StStash: begin
        if (e) begin exit_ok = 1'b1; dest = StRiver; end
      end
      default: begin
        exit_ok = 1'b0;
        dest    = state;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StCave;
      win   <= 1'b0;
      d     <= 1'b0;
      sword <= 1'b0;
      bump  <= 1'b0;
      lives <= LivesInit;
      moves <= '0;
    end else begin
      bump <= 1'b0;
      unique case (state)
        // Den resolves unconditionally and outranks the timeout.
        StDen: begin
          if (sword) begin
            state <= StVault;
            win   <= 1'b1;
          end else if (lives > CNT_W'(1)) begin
            lives <= lives - 1'b1;
            state <= StCave;
          end else begin
            lives <= '0;
            state <= StGrave;
            d     <= 1'b1;
          end
        end
        StVault, StGrave: begin
          state <= state;
        end
        default: begin
          if (timeout) begin
            state <= StGrave;
            d     <= 1'b1;
          end else if (single && exit_ok) begin
            state <= dest;
            if (dest == StStash) sword <= 1'b1;
            if (moves != MoveMax) moves <= moves + 1'b1;
          end else if (any_btn) begin
            bump <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adventure_fsm_gen.sv
// Scoreboard bench for adventure_fsm_gen: directed game scenarios followed by
// random button traffic, checked against a room-index reference model.
module tb_adventure_fsm_gen;

  localparam int unsigned Lives     = 2;
  localparam int unsigned CntW      = 4;
  localparam int unsigned MoveLimit = 4;
`ifdef ADV_MOVE_LIMIT_EN
  localparam int TimeoutEn = 1;
  localparam int SatMax    = MoveLimit;
`else
  localparam int TimeoutEn = 0;
  localparam int SatMax    = 15;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            n, s, e, w;
  logic [6:0]      room;
  logic            win, d, sword, bump;
  logic [CntW-1:0] lives, moves;

  adventure_fsm_gen #(
    .LIVES      (Lives),
    .CNT_W      (CntW),
    .MOVE_LIMIT (MoveLimit)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .n     (n),
    .s     (s),
    .e     (e),
    .w     (w),
    .room  (room),
    .win   (win),
    .d     (d),
    .sword (sword),
    .lives (lives),
    .moves (moves),
    .bump  (bump)
  );

  always #5 clk = ~clk;

  // Packed observation: room, win, d, sword, lives, moves, bump.
  typedef logic [18:0] obs_t;

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: rooms as indices 0..6 (Cave..Graveyard).
  int exit_to[4][4];  // [room][dir n,s,e,w], -1 = no exit
  int m_room, m_lives, m_moves;
  bit m_sword, m_bump;

  function automatic obs_t pack_model();
    logic [6:0] r;
    r = 7'd1 << m_room;
    return {r, (m_room == 5), (m_room == 6), m_sword, 4'(m_lives), 4'(m_moves), m_bump};
  endfunction

  function automatic obs_t pack_dut();
    return {room, win, d, sword, lives, moves, bump};
  endfunction

  task automatic model_reset();
    m_room = 0; m_lives = Lives; m_moves = 0; m_sword = 0; m_bump = 0;
  endtask

  task automatic model_step(input logic [3:0] b);
    int cnt;
    int dir;
    cnt    = $countones(b);
    dir    = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
    m_bump = 0;
    if (m_room == 4) begin
      if (m_sword) m_room = 5;
      else if (m_lives > 1) begin m_lives = m_lives - 1; m_room = 0; end
      else begin m_lives = 0; m_room = 6; end
    end else if (m_room >= 5) begin
      m_room = m_room;
    end else if (TimeoutEn != 0 && m_moves == MoveLimit) begin
      m_room = 6;
    end else if (cnt == 1 && exit_to[m_room][dir] >= 0) begin
      m_room = exit_to[m_room][dir];
      if (m_room == 3) m_sword = 1;
      if (m_moves < SatMax) m_moves = m_moves + 1;
    end else if (cnt != 0) begin
      m_bump = 1;
    end
  endtask

  function automatic void check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got room=%h win=%b d=%b sword=%b lives=%0d moves=%0d bump=%b, required room=%h win=%b d=%b sword=%b lives=%0d moves=%0d bump=%b",
               name, act[18:12], act[11], act[10], act[9], act[8:5], act[4:1], act[0],
               exp[18:12], exp[11], exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
    end
  endfunction

  // Monitor: the DUT presents a new observation after every edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) check("step", pack_dut(), sb.pop_front());
  end

  task automatic step(input logic [3:0] b);
    @(negedge clk);
    {n, s, e, w} = b;
    model_step(b);
    sb.push_back(pack_model());
  endtask

  // Reset asserted and released between edges; its effect is checked at once.
  task automatic do_reset();
    @(negedge clk);
    {n, s, e, w} = 4'b0000;
    reset = 1'b1;
    model_reset();
    #2 check("reset", pack_dut(), pack_model());
    #1 reset = 1'b0;
  endtask

  localparam logic [3:0] BN = 4'b1000, BS = 4'b0100, BE = 4'b0010, BW = 4'b0001,
                         BI = 4'b0000;

  initial begin
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) exit_to[r][k] = -1;
    exit_to[0][2] = 1;
    exit_to[1][3] = 0; exit_to[1][1] = 2;
    exit_to[2][0] = 1; exit_to[2][3] = 3; exit_to[2][2] = 4;
    exit_to[3][2] = 2;

    reset = 1'b1;
    {n, s, e, w} = 4'b0000;
    model_reset();
    do_reset();

    // Respawn, then dragon death on the last life.
    step(BE); step(BS); step(BE); step(BI);
    step(BE); step(BS); step(BE); step(BI); step(BE);

    // Win, then inputs are ignored in the Vault.
    do_reset();
    step(BE); step(BS); step(BW); step(BE); step(BE); step(BI); step(BN); step(BE);

    // Bumps: non-exit in Cave, double press in River.
    do_reset();
    step(BN); step(BI); step(BE); step(BS); step(BE | BW); step(BI); step(4'b1111);

    // Move-limit sequence.
    do_reset();
    step(BE); step(BW); step(BE); step(BW); step(BI); step(BI);

    // Async reset mid-game from the Stash.
    do_reset();
    step(BE); step(BS); step(BW);
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1 check("async_reset", pack_dut(), pack_model());
    #1 reset = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] b;
      r = $urandom_range(0, 9);
      if (r < 2) b = BI;
      else if (r < 8) b = 4'(1 << $urandom_range(0, 3));
      else b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) do_reset();
      step(b);
    end

    @(negedge clk);
    {n, s, e, w} = 4'b0000;
    @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
